msk_rnd_source: RTL and testbench
=================================

# msk_rnd_source

Seeded pseudo-random source feeding the `rnd` inputs of masked gadgets such as refresh and multiplication. It is the producer end of the gadget randomness bus, and delivers N_RND fresh bits per accepted transfer. The block holds an LFSR that is seeded over a handshake and warmed up before any output. It tracks output volume and requests reseeding when that volume reaches a set limit.

## Interface
- N_RND, 2, bits per output word; 1..32.
- WARMUP_CYC, 4, LFSR advance cycles after each seed before output; 0..255.
- RESEED_INTERVAL, 16'hFFFF, accepted words after which `reseed_req` asserts; 1..65535.
- HEALTH_LIMIT, 8, consecutive identical accepted words that trip the health test; 2..255. Used only with the BIST option.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- seed  in  32  seed value.
- seed_valid  in  1  seed offered.
- seed_ready  out  1  seed can be accepted.
- rnd  out  N_RND  random word.
- rnd_valid  out  1  `rnd` is fresh.
- rnd_ready  in  1  gadget consumes `rnd` this cycle.
- reseed_req  out  1  output budget exhausted.
- health_fail  out  1  sticky health-test failure.

Clock: one clock. Reset: synchronous, active-low.

## Operation
- **LFSR:** 32-bit Fibonacci. One step is fb = s[31]^s[21]^s[1]^s[0], then s <= {s[30:0], fb}. One advance is N_RND steps, unrolled.
- **Output:** `rnd` = s[N_RND-1:0], taken directly from the state register.
- **FSM states:** IDLE, WARMUP, RUN.
- **IDLE:** `seed_ready`=1, `rnd_valid`=0.
  - On seed accept, s <= seed. A seed of 0 is replaced by 32'h1.
  - Go to WARMUP if WARMUP_CYC>0, otherwise go to RUN.
- **WARMUP:** `seed_ready`=0, `rnd_valid`=0.
  - Advance once per cycle for WARMUP_CYC cycles, then go to RUN.
  - `seed_valid` is ignored here.
- **RUN:** `seed_ready`=1, `rnd_valid`=1.
  - On rnd_valid&&rnd_ready, advance once. The word counter then increments, saturating at RESEED_INTERVAL.
  - No advance occurs without an accept, so `rnd` holds stable while stalled.
- **reseed_req:** asserts when the word counter equals RESEED_INTERVAL. Output continues after that.
- **Seed accept in RUN:** load s as in IDLE, clear the counter and `reseed_req`, then enter WARMUP or RUN as above.
- **Simultaneous rnd accept and seed accept:** both count as handshakes. The seed load wins the state update. The current word is consumed and is never re-presented.
- **Freshness invariant:** no LFSR bit is exposed in two accepted words. This is guaranteed by N_RND ≤ 32 and a full advance per accept.
- **Reset values:** FSM=IDLE, s=0, `rnd`=0, `rnd_valid`=0, `reseed_req`=0, `health_fail`=0, counter=0.
- **seed_ready during reset:** it is 0 while rst_n=0 and 1 in the first cycle after release.
- **Reset mid-operation:** aborts warmup or run and returns to IDLE. Seed state is not retained.

## Timing
- **Seed accepted at edge T:** the FSM enters WARMUP (or RUN) at T+1.
- **rnd_valid rise:** `rnd_valid` rises at T+WARMUP_CYC+1.
- **Word update:** a transfer accepted at edge E presents the next word at E+1. Back-to-back transfers run one per cycle.
- **Output registering:** all outputs are registered or are a decode of FSM state only. There is no combinational path from `rnd_ready` or `seed_valid` to any output.
- **reseed_req timing:** asserts the cycle after the accept that brings the counter to RESEED_INTERVAL.

## Configuration
- **MSK_RND_BIST_EN defined:**
  - A repetition counter compares each accepted word with the previous accepted word, and counts consecutive equal words.
  - When the count reaches HEALTH_LIMIT, `health_fail` sets (sticky) and `rnd_valid` is forced to 0.
  - Only a seed accept or a reset clears the failure. The counter clears on seed.
- **MSK_RND_BIST_EN undefined:** `health_fail` is tied to 0, and no comparator or counter is built.

## Structure
- **Package msk_rnd_pkg:** FSM state enum, LFSR width (32), tap positions, zero-seed substitute (32'h1).
- **Sub-module msk_lfsr_adv:** combinational, parameterized by N_RND, computes the N_RND-step advance. It is shared by the warmup and run paths.

## Test plan
- **Basic sequence:** WARMUP_CYC=0, N_RND=2, seed 32'h1 accepted at T.
  - `rnd_valid` is 1 at T+1.
  - With `rnd_ready` held at 1, `rnd` runs 2'b01, 2'b10, 2'b11.
  - s runs 1→6→27.
- **Zero seed:** seed 32'h0 → identical output sequence to seed 32'h1.
- **Stall:** `rnd_ready` held at 0 for 5 cycles in RUN → `rnd` constant, word counter unchanged. The next accept yields the next sequence value.
- **Reseed budget:** RESEED_INTERVAL=3.
  - `reseed_req` rises the cycle after the 3rd accept.
  - A new seed clears `reseed_req` at the next edge.
  - With WARMUP_CYC=4, `rnd_valid` is 0 for 4 cycles.
- **Reset mid-warmup:** rst_n=0 one cycle during WARMUP → IDLE, all outputs at reset values, `seed_ready`=1 after release.
- **Health test (MSK_RND_BIST_EN, HEALTH_LIMIT=8):** force s to 0 in RUN → after 8 equal accepted words, `health_fail`=1 and `rnd_valid`=0. A seed clears `health_fail`.

Source files
------------

// File: rtl/msk_rnd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : msk_rnd_pkg
// Purpose : Shared types and constants for the masked-gadget randomness source.
// Revision: 1.0
// ============================================================================
package msk_rnd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_e;

   localparam int LFSR_W = 32;
   localparam int TAP_A  = 31;
   localparam int TAP_B  = 21;
   localparam int TAP_C  = 1;
   localparam int TAP_D  = 0;

   // An all-zero LFSR is a fixed point, so a zero seed is replaced by this.
   localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h1;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/msk_lfsr_adv.sv
`default_nettype none
// ============================================================================
// Module  : msk_lfsr_adv
// Purpose : Combinational N_RND-step advance of the 32-bit Fibonacci LFSR.
// Revision: 1.0
// ============================================================================
module msk_lfsr_adv
   import msk_rnd_pkg::*;
#(
   parameter int N_RND = 2
)(
   input  logic [LFSR_W-1:0] s_in,
   output logic [LFSR_W-1:0] s_out
);

   logic [LFSR_W-1:0] stage [0:N_RND];

   assign stage[0] = s_in;

   for (genvar i = 0; i < N_RND; i++) begin : g_step
      assign stage[i+1] = lfsr_step(stage[i]);
   end

   assign s_out = stage[N_RND];

endmodule
`default_nettype wire

// File: rtl/msk_rnd_source.sv
`default_nettype none
// ============================================================================
// Module  : msk_rnd_source
// Purpose : Seeded, warmed-up LFSR producer for gadget randomness with reseed
//           budget; optional repetition health test under MSK_RND_BIST_EN.
// Revision: 1.0
// ============================================================================
module msk_rnd_source
   import msk_rnd_pkg::*;
#(
   parameter int N_RND           = 2,
   parameter int WARMUP_CYC      = 4,
   parameter int RESEED_INTERVAL = 16'hFFFF,
   parameter int HEALTH_LIMIT    = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       seed,
   input  logic              seed_valid,
   output logic              seed_ready,
   output logic [N_RND-1:0]  rnd,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              reseed_req,
   output logic              health_fail
);

   localparam logic [7:0]  WARM_LAST = 8'(WARMUP_CYC - 1);
   localparam logic [15:0] CNT_MAX   = 16'(RESEED_INTERVAL);

   state_e            state, state_nx;
   logic [LFSR_W-1:0] s, s_nx, s_adv, s_seed;
   logic [7:0]        warm, warm_nx;
   logic [15:0]       cnt, cnt_nx;
   logic              reseed_nx;
   logic              seed_acc, rnd_acc;

   msk_lfsr_adv #(.N_RND(N_RND)) u_adv (
      .s_in  (s),
      .s_out (s_adv)
   );

   assign s_seed     = (seed == '0) ? ZERO_SEED_SUB : seed;
   assign seed_ready = rst_n && (state != ST_WARMUP);
   assign rnd        = s[N_RND-1:0];
   assign seed_acc   = seed_valid && seed_ready;
   assign rnd_acc    = rnd_valid && rnd_ready;

   // A seed load takes priority; a word accepted in the same cycle is dropped.
   always_comb begin
      state_nx  = state;
      s_nx      = s;
      warm_nx   = warm;
      cnt_nx    = cnt;
      reseed_nx = reseed_req;
      if (seed_acc) begin
         s_nx      = s_seed;
         cnt_nx    = '0;
         reseed_nx = 1'b0;
         warm_nx   = '0;
         state_nx  = (WARMUP_CYC > 0) ? ST_WARMUP : ST_RUN;
      end else begin
         case (state)
            ST_WARMUP: begin
               s_nx    = s_adv;
               warm_nx = warm + 8'd1;
               if (warm == WARM_LAST) state_nx = ST_RUN;
            end
            ST_RUN: begin
               if (rnd_acc) begin
                  s_nx = s_adv;
                  if (cnt != CNT_MAX) cnt_nx = cnt + 16'd1;
                  reseed_nx = (cnt_nx == CNT_MAX);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         s          <= '0;
         warm       <= '0;
         cnt        <= '0;
         reseed_req <= 1'b0;
      end else begin
         state      <= state_nx;
         s          <= s_nx;
         warm       <= warm_nx;
         cnt        <= cnt_nx;
         reseed_req <= reseed_nx;
      end
   end

`ifdef MSK_RND_BIST_EN
   localparam logic [7:0] REP_LIMIT = 8'(HEALTH_LIMIT);

   logic [N_RND-1:0] prev;
   logic             have_prev;
   logic             fail;
   logic [7:0]       rep, rep_inc;

   assign rep_inc     = rep + 8'd1;
   assign rnd_valid   = (state == ST_RUN) && !fail;
   assign health_fail = fail;

   // rep holds the length of the current run of identical accepted words.
   always_ff @(posedge clk) begin
      if (!rst_n || seed_acc) begin
         prev      <= '0;
         have_prev <= 1'b0;
         rep       <= '0;
         fail      <= 1'b0;
      end else if (rnd_acc) begin
         prev      <= rnd;
         have_prev <= 1'b1;
         if (have_prev && (rnd == prev)) begin
            rep <= rep_inc;
            if (rep_inc >= REP_LIMIT) fail <= 1'b1;
         end else begin
            rep <= 8'd1;
         end
      end
   end
`else
   logic [7:0] unused_health_limit;

   assign unused_health_limit = 8'(HEALTH_LIMIT);
   assign rnd_valid           = (state == ST_RUN);
   assign health_fail         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msk_rnd_source.sv
`default_nettype none
// ============================================================================
// Module  : tb_msk_rnd_source
// Purpose : Self-checking bench for msk_rnd_source (two configurations driven
//           by shared stimulus) against a behavioural reference model.
// Revision: 1.0
// ============================================================================
module tb_msk_rnd_source;

   localparam int M_IDLE = 0;
   localparam int M_WARM = 1;
   localparam int M_RUN  = 2;
   localparam int HL     = 8;

   logic        clk;
   logic        rst_n;
   logic [31:0] seed;
   logic        seed_valid;
   logic        rnd_ready;

   logic        seed_ready_a, rnd_valid_a, reseed_req_a, health_fail_a;
   logic [1:0]  rnd_a;
   logic        seed_ready_b, rnd_valid_b, reseed_req_b, health_fail_b;
   logic [4:0]  rnd_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit model_on = 1'b1;

   int          mode  [2];
   logic [31:0] ms    [2];
   int          wleft [2];
   int          mcnt  [2];
   int          mrun  [2];
   bit          mreq  [2];
   bit          mfail [2];
   logic [31:0] mprev [2];

   msk_rnd_source #(.N_RND(2), .WARMUP_CYC(0), .RESEED_INTERVAL(3), .HEALTH_LIMIT(HL)) dut_a (
      .clk(clk), .rst_n(rst_n), .seed(seed), .seed_valid(seed_valid),
      .seed_ready(seed_ready_a), .rnd(rnd_a), .rnd_valid(rnd_valid_a),
      .rnd_ready(rnd_ready), .reseed_req(reseed_req_a), .health_fail(health_fail_a)
   );

   msk_rnd_source #(.N_RND(5), .WARMUP_CYC(4), .RESEED_INTERVAL(3), .HEALTH_LIMIT(HL)) dut_b (
      .clk(clk), .rst_n(rst_n), .seed(seed), .seed_valid(seed_valid),
      .seed_ready(seed_ready_b), .rnd(rnd_b), .rnd_valid(rnd_valid_b),
      .rnd_ready(rnd_ready), .reseed_req(reseed_req_b), .health_fail(health_fail_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mask(input int n);
      return (32'h1 << n) - 32'h1;
   endfunction

   // n single-bit shifts of the Fibonacci register
   function automatic logic [31:0] adv(input logic [31:0] s, input int n);
      logic [31:0] r;
      r = s;
      for (int k = 0; k < n; k++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
      return r;
   endfunction

   task automatic model_edge(input int i, input int n, input int w, input int ri);
      bit sacc, racc;
      logic [31:0] word;
      if (!rst_n) begin
         mode[i] = M_IDLE; ms[i] = '0; mcnt[i] = 0; mreq[i] = 0;
         mfail[i] = 0; mrun[i] = 0; wleft[i] = 0; mprev[i] = '0;
         return;
      end
      sacc = seed_valid && (mode[i] != M_WARM);
      racc = (mode[i] == M_RUN) && !mfail[i] && rnd_ready;
      word = ms[i] & mask(n);
      if (sacc) begin
         ms[i]   = (seed == 32'h0) ? 32'h1 : seed;
         mcnt[i] = 0; mreq[i] = 0; mfail[i] = 0; mrun[i] = 0;
         wleft[i] = w;
         mode[i]  = (w > 0) ? M_WARM : M_RUN;
      end else if (mode[i] == M_WARM) begin
         ms[i] = adv(ms[i], n);
         wleft[i]--;
         if (wleft[i] == 0) mode[i] = M_RUN;
      end else if (racc) begin
         ms[i] = adv(ms[i], n);
         if (mcnt[i] < ri) mcnt[i]++;
         mreq[i] = (mcnt[i] == ri);
         if (mrun[i] > 0 && word == mprev[i]) mrun[i]++;
         else mrun[i] = 1;
         mprev[i] = word;
`ifdef MSK_RND_BIST_EN
         if (mrun[i] >= HL) mfail[i] = 1;
`endif
      end
   endtask

   task automatic compare_all();
      check_eq("A.rnd",        32'(rnd_a),         ms[0] & mask(2));
      check_eq("A.rnd_valid",  32'(rnd_valid_a),   32'(mode[0] == M_RUN && !mfail[0]));
      check_eq("A.seed_ready", 32'(seed_ready_a),  32'(rst_n && mode[0] != M_WARM));
      check_eq("A.reseed_req", 32'(reseed_req_a),  32'(mreq[0]));
      check_eq("A.health",     32'(health_fail_a), 32'(mfail[0]));
      check_eq("B.rnd",        32'(rnd_b),         ms[1] & mask(5));
      check_eq("B.rnd_valid",  32'(rnd_valid_b),   32'(mode[1] == M_RUN && !mfail[1]));
      check_eq("B.seed_ready", 32'(seed_ready_b),  32'(rst_n && mode[1] != M_WARM));
      check_eq("B.reseed_req", 32'(reseed_req_b),  32'(mreq[1]));
      check_eq("B.health",     32'(health_fail_b), 32'(mfail[1]));
   endtask

   task automatic step_cycle();
      @(posedge clk);
      if (model_on) begin
         model_edge(0, 2, 0, 3);
         model_edge(1, 5, 4, 3);
      end
      #1;
      if (model_on) compare_all();
   endtask

   initial begin
      rst_n = 1'b0; seed = '0; seed_valid = 1'b0; rnd_ready = 1'b0;
      repeat (2) step_cycle();
      check_eq("rst.seed_ready", 32'(seed_ready_a), 32'h0);
      rst_n = 1'b1;
      step_cycle();
      check_eq("rel.seed_ready", 32'(seed_ready_a), 32'h1);

      // seed 1, no warmup on A: 01, 10, 11
      seed = 32'h1; seed_valid = 1'b1; rnd_ready = 1'b1;
      step_cycle();
      check_eq("basic.valid", 32'(rnd_valid_a), 32'h1);
      check_eq("basic.rnd0",  32'(rnd_a), 32'h1);
      seed_valid = 1'b0;
      step_cycle();
      check_eq("basic.rnd1",  32'(rnd_a), 32'h2);
      step_cycle();
      check_eq("basic.rnd2",  32'(rnd_a), 32'h3);
      check_eq("reseed.pre",  32'(reseed_req_a), 32'h0);
      step_cycle();
      check_eq("reseed.post", 32'(reseed_req_a), 32'h1);
      check_eq("warm.B_low",  32'(rnd_valid_b), 32'h0);
      step_cycle();
      check_eq("warm.B_high", 32'(rnd_valid_b), 32'h1);

      // zero seed behaves as seed 1 and clears the reseed request
      seed = 32'h0; seed_valid = 1'b1;
      step_cycle();
      check_eq("zero.rnd0",   32'(rnd_a), 32'h1);
      check_eq("zero.reseed", 32'(reseed_req_a), 32'h0);
      seed_valid = 1'b0;
      step_cycle();
      check_eq("zero.rnd1",   32'(rnd_a), 32'h2);
      step_cycle();
      check_eq("zero.rnd2",   32'(rnd_a), 32'h3);

      rnd_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step_cycle();
         check_eq("stall.rnd",    32'(rnd_a), 32'h3);
         check_eq("stall.reseed", 32'(reseed_req_a), 32'h0);
      end
      rnd_ready = 1'b1;
      step_cycle();
      check_eq("stall.next",   32'(rnd_a), 32'h1);
      check_eq("stall.reseed", 32'(reseed_req_a), 32'h1);

      // reset while B is warming up
      seed = 32'hdeadbeef; seed_valid = 1'b1;
      step_cycle();
      seed_valid = 1'b0;
      step_cycle();
      rst_n = 1'b0;
      step_cycle();
      check_eq("rstw.valid", 32'(rnd_valid_b), 32'h0);
      check_eq("rstw.rnd",   32'(rnd_b), 32'h0);
      rst_n = 1'b1;
      step_cycle();
      check_eq("rstw.ready", 32'(seed_ready_b), 32'h1);

      for (int k = 0; k < 1500; k++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         seed_valid = ($urandom_range(0, 11) == 0);
         seed       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         rnd_ready  = ($urandom_range(0, 3) != 0);
         step_cycle();
      end

`ifdef MSK_RND_BIST_EN
      rst_n = 1'b1; seed = 32'h5; seed_valid = 1'b1; rnd_ready = 1'b1;
      step_cycle();
      seed_valid = 1'b0;
      model_on = 1'b0;
      force dut_a.s = 32'h0;
      for (int k = 1; k <= HL; k++) begin
         step_cycle();
         if (k == HL - 1) check_eq("bist.before", 32'(health_fail_a), 32'h0);
      end
      check_eq("bist.fail",  32'(health_fail_a), 32'h1);
      check_eq("bist.valid", 32'(rnd_valid_a), 32'h0);
      release dut_a.s;
      seed_valid = 1'b1;
      step_cycle();
      check_eq("bist.clear", 32'(health_fail_a), 32'h0);
      seed_valid = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
